// File: rtl/cmp_sweep_checker.sv
// Exhaustive stimulus-and-check engine for a WIDTH-bit magnitude comparator.
// Sweeps every (A, B) pair and records the error count and first failing pair.
module cmp_sweep_checker #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic               i_CLK,
    input  logic               i_RST_N,
    input  logic               i_START,
    output logic [WIDTH-1:0]   o_OPERAND_A,
    output logic [WIDTH-1:0]   o_OPERAND_B,
    input  logic               i_A_GT_B,
    input  logic               i_A_EQ_B,
    input  logic               i_A_LT_B,
    output logic               o_BUSY,
    output logic               o_DONE,
    output logic               o_PASS,
    output logic [2*WIDTH:0]   o_ERR_COUNT,
    output logic [WIDTH-1:0]   o_FIRST_ERR_A,
    output logic [WIDTH-1:0]   o_FIRST_ERR_B
);

    localparam int KW = 2 * WIDTH;
    localparam int EW = 2 * WIDTH + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DRIVE  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    // SETTLE lasts SETTLE_CYCLES cycles: counter starts one below that.
    localparam logic [3:0] CNT_INIT =
        (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

    logic [2:0]       state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [EW-1:0]    err_q, err_d;
    logic [WIDTH-1:0] fea_q, fea_d;
    logic [WIDTH-1:0] feb_q, feb_d;

    logic [2:0] exp_flags;
    logic [2:0] got_flags;
    logic       mismatch;

    // Golden compare of the pair currently held on the operand registers.
    always_comb begin
        exp_flags = {opa_q > opb_q, opa_q == opb_q, opa_q < opb_q};
        got_flags = {i_A_GT_B, i_A_EQ_B, i_A_LT_B};
        mismatch  = (exp_flags != got_flags);
    end

    // Next-state logic for the sweep sequencer and result registers.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fea_d   = fea_q;
        feb_d   = feb_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (i_START) begin
                    err_d   = '0;
                    fea_d   = '0;
                    feb_d   = '0;
                    k_d     = '0;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                opa_d = k_q[KW-1:WIDTH];
                opb_d = k_q[WIDTH-1:0];
                if (SETTLE_CYCLES == 0) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    if (err_q != '1) begin
                        err_d = err_q + 1'b1;
                    end
                    if (err_q == '0) begin
                        fea_d = opa_q;
                        feb_d = opb_q;
                    end
                end
                if (k_q == '1) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = S_DRIVE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers; reset discards any partial sweep.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fea_q   <= '0;
            feb_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fea_q   <= fea_d;
            feb_q   <= feb_d;
        end
    end

    assign o_OPERAND_A   = opa_q;
    assign o_OPERAND_B   = opb_q;
    assign o_BUSY        = (state_q == S_DRIVE) || (state_q == S_SETTLE)
                         || (state_q == S_CHECK);
    assign o_DONE        = (state_q == S_DONE);
    assign o_PASS        = (state_q == S_DONE) && (err_q == '0);
    assign o_ERR_COUNT   = err_q;
    assign o_FIRST_ERR_A = fea_q;
    assign o_FIRST_ERR_B = feb_q;

endmodule

// File: tb/tb_cmp_sweep_checker.sv
// Bench for cmp_sweep_checker: two instances (settle 0 and 1) driven by
// faulty/ideal comparator models, checked every cycle against a pair-level model.
module tb_cmp_sweep_checker;

    logic       clk = 1'b0;
    logic       rst_n [2];
    logic       start [2];
    logic [3:0] opa   [2];
    logic [3:0] opb   [2];
    logic       gt    [2];
    logic       eq    [2];
    logic       lt    [2];
    logic       busy  [2];
    logic       done  [2];
    logic       pass  [2];
    logic [8:0] errc  [2];
    logic [3:0] fea   [2];
    logic [3:0] feb   [2];
    int         mode  [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Comparator behaviour: 0 ideal, 1 EQ stuck 0, 2 GT/LT swapped,
    // 3 all flags high, 4 ideal but one cycle late (handled in the loop).
    function automatic logic [2:0] cmpf(int m, logic [3:0] a, logic [3:0] b);
        logic [2:0] id;
        id = {a > b, a == b, a < b};
        case (m)
            1:       return id & 3'b101;
            2:       return {id[0], id[1], id[2]};
            3:       return 3'b111;
            default: return id;
        endcase
    endfunction

    // Which of the 256 pairs must be flagged, given the comparator model,
    // the settle time and the operands shown before the sweep began.
    function automatic logic [255:0] calc_fail(int m, int s, logic [7:0] prev);
        logic [255:0] f;
        logic [7:0]   q8;
        logic [7:0]   seen;
        f = '0;
        for (int q = 0; q < 256; q++) begin
            q8 = 8'(q);
            if (m == 4) begin
                if (s == 0) seen = (q == 0) ? prev : 8'(q - 1);
                else        seen = q8;
                f[q] = cmpf(0, seen[7:4], seen[3:0]) != cmpf(0, q8[7:4], q8[3:0]);
            end else begin
                f[q] = cmpf(m, q8[7:4], q8[3:0]) != cmpf(0, q8[7:4], q8[3:0]);
            end
        end
        return f;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g
        localparam int L = 2 + gi;

        logic [2:0] dly;
        logic [2:0] fl;

        cmp_sweep_checker #(.WIDTH(4), .SETTLE_CYCLES(gi)) u_dut (
            .i_CLK        (clk),
            .i_RST_N      (rst_n[gi]),
            .i_START      (start[gi]),
            .o_OPERAND_A  (opa[gi]),
            .o_OPERAND_B  (opb[gi]),
            .i_A_GT_B     (gt[gi]),
            .i_A_EQ_B     (eq[gi]),
            .i_A_LT_B     (lt[gi]),
            .o_BUSY       (busy[gi]),
            .o_DONE       (done[gi]),
            .o_PASS       (pass[gi]),
            .o_ERR_COUNT  (errc[gi]),
            .o_FIRST_ERR_A(fea[gi]),
            .o_FIRST_ERR_B(feb[gi])
        );

        always @(posedge clk) dly <= cmpf(0, opa[gi], opb[gi]);

        always_comb begin
            fl = (mode[gi] == 4) ? dly : cmpf(mode[gi], opa[gi], opb[gi]);
        end
        assign gt[gi] = fl[2];
        assign eq[gi] = fl[1];
        assign lt[gi] = fl[0];

        // Model: cycles elapsed since the accepted START edge.
        bit           run = 1'b0;
        int           t   = 0;
        logic [255:0] fv  = '0;
        logic [7:0]   pv  = '0;

        always @(posedge clk or negedge rst_n[gi]) begin
            if (!rst_n[gi]) begin
                run <= 1'b0;
                t   <= 0;
            end else if (start[gi] && !(run && t < 256 * L)) begin
                pv  <= run ? 8'hFF : 8'h00;
                fv  <= calc_fail(mode[gi], gi, run ? 8'hFF : 8'h00);
                run <= 1'b1;
                t   <= 0;
            end else if (run) begin
                t <= t + 1;
            end
        end

        int         p, ph, nchk, cnt, fq;
        logic [7:0] eop, efe;
        logic       eb, ed, ep;

        always @(negedge clk) begin
            eop = 8'h00; eb = 1'b0; ed = 1'b0;
            cnt = 0; fq = -1; nchk = 0;
            if (rst_n[gi] && run) begin
                p  = t / L;
                ph = t % L;
                if (t >= 256 * L) begin
                    eop = 8'hFF; ed = 1'b1; nchk = 256;
                end else begin
                    eb   = 1'b1;
                    nchk = p;
                    if (ph != 0)     eop = 8'(p);
                    else if (p == 0) eop = pv;
                    else             eop = 8'(p - 1);
                end
                for (int q = 0; q < nchk; q++) begin
                    if (fv[q]) begin
                        cnt++;
                        if (fq < 0) fq = q;
                    end
                end
            end
            ep  = ed && (cnt == 0);
            efe = (fq < 0) ? 8'h00 : 8'(fq);
            chk($sformatf("u%0d_opa", gi), opa[gi], eop[7:4]);
            chk($sformatf("u%0d_opb", gi), opb[gi], eop[3:0]);
            chk($sformatf("u%0d_busy", gi), busy[gi], eb);
            chk($sformatf("u%0d_done", gi), done[gi], ed);
            chk($sformatf("u%0d_pass", gi), pass[gi], ep);
            chk($sformatf("u%0d_errc", gi), errc[gi], cnt);
            chk($sformatf("u%0d_fea", gi), fea[gi], efe[7:4]);
            chk($sformatf("u%0d_feb", gi), feb[gi], efe[3:0]);
        end
    end

    // Pulse START, then count edges until DONE; optional stray START at edge `stray`.
    task automatic sweep(input int i, input int stray, output int n);
        @(posedge clk); #1 start[i] = 1'b1;
        @(posedge clk); #1 start[i] = 1'b0;
        chk("busy_after_start", busy[i], 1);
        n = 0;
        while (!done[i] && n < 2000) begin
            @(posedge clk); #1;
            n++;
            start[i] = (n == stray);
        end
        start[i] = 1'b0;
    endtask

    int n;

    initial begin
        rst_n[0] = 1'b0; rst_n[1] = 1'b0;
        start[0] = 1'b0; start[1] = 1'b0;
        mode[0]  = 0;    mode[1]  = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy[1], 0);
        chk("rst_done", done[0], 0);
        chk("rst_errc", errc[1], 0);
        chk("rst_ops", {opa[0], opb[0]}, 0);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;

        mode[1] = 0;
        sweep(1, 0, n);
        chk("ideal_lat", n, 768);
        chk("ideal_errc", errc[1], 0);
        chk("ideal_pass", pass[1], 1);
        chk("ideal_fe", {fea[1], feb[1]}, 8'h00);

        mode[1] = 1;
        sweep(1, 0, n);
        chk("eq0_errc", errc[1], 16);
        chk("eq0_pass", pass[1], 0);
        chk("eq0_fe", {fea[1], feb[1]}, 8'h00);

        mode[1] = 2;
        sweep(1, 0, n);
        chk("swap_errc", errc[1], 240);
        chk("swap_fe", {fea[1], feb[1]}, 8'h01);

        mode[0] = 3;
        sweep(0, 0, n);
        chk("all_lat", n, 512);
        chk("all_errc", errc[0], 256);
        chk("all_fe", {fea[0], feb[0]}, 8'h00);

        mode[0] = 4;
        sweep(0, 0, n);
        chk("late_s0_errc", errc[0], 45);
        chk("late_s0_pass", pass[0], 0);

        mode[1] = 4;
        sweep(1, 0, n);
        chk("late_s1_errc", errc[1], 0);
        chk("late_s1_pass", pass[1], 1);

        mode[1] = 0;
        sweep(1, 50, n);
        chk("stray_lat", n, 768);

        mode[1] = 1;
        @(posedge clk); #1 start[1] = 1'b1;
        @(posedge clk); #1 start[1] = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        chk("mid_errc_nz", errc[1] != 0, 1);
        rst_n[1] = 1'b0;
        #1;
        chk("mid_rst_busy", busy[1], 0);
        chk("mid_rst_errc", errc[1], 0);
        chk("mid_rst_ops", {opa[1], opb[1]}, 0);
        chk("mid_rst_fe", {fea[1], feb[1]}, 0);
        @(posedge clk); #1 rst_n[1] = 1'b1;

        mode[1] = 0;
        sweep(1, 0, n);
        chk("restart_lat", n, 768);
        chk("restart_pass", pass[1], 1);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmp_sweep_checker.md
Name: cmp_sweep_checker

Overview:
- Sequential stimulus-and-check engine that sits on the driving side of the 4-bit magnitude comparator.
- On start, it generates every (A, B) operand pair and presents each pair to the comparator.
- After a programmable settle time, it samples the comparator's three result flags and checks them against an internal golden compare.
- It reports the error count, the first failing pair and a pass/done status. It is used for built-in self-test and for formal/simulation cover closure.

Parameters:
- WIDTH, 4, operand width in bits; the sweep covers 2^(2*WIDTH) pairs.
- SETTLE_CYCLES, 1, cycles to wait between driving a pair and sampling flags; legal range 0..15.

Ports:
- i_CLK  input  1  clock; all state changes on the rising edge.
- i_RST_N  input  1  asynchronous active-low reset.
- i_START  input  1  one-cycle pulse that begins a sweep; honoured only in IDLE or DONE.
- o_OPERAND_A  output  WIDTH  operand A to the comparator.
- o_OPERAND_B  output  WIDTH  operand B to the comparator.
- i_A_GT_B  input  1  comparator flag, A > B.
- i_A_EQ_B  input  1  comparator flag, A == B.
- i_A_LT_B  input  1  comparator flag, A < B.
- o_BUSY  output  1  high while a sweep is in progress.
- o_DONE  output  1  sticky high after the last pair has been checked.
- o_PASS  output  1  high with o_DONE when o_ERR_COUNT == 0.
- o_ERR_COUNT  output  2*WIDTH+1  number of failing pairs; saturates at all-ones.
- o_FIRST_ERR_A  output  WIDTH  A of the first failing pair; 0 if none.
- o_FIRST_ERR_B  output  WIDTH  B of the first failing pair; 0 if none.

Behaviour:
- Reset (asynchronous assert, synchronous deassert at first edge):
  - State goes to IDLE.
  - All outputs are 0: operands, BUSY, DONE, PASS, ERR_COUNT, FIRST_ERR_A/B.
  - Pair index is 0.
- Pair index k is 2*WIDTH bits wide:
  - o_OPERAND_A = k[2W-1:W], o_OPERAND_B = k[W-1:0].
  - Sweep order is A outer, B inner: (0,0), (0,1), ..., (0,15), (1,0), ..., (15,15) for W=4.
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
  - IDLE: operands 0, BUSY=0. On i_START: clear ERR_COUNT, FIRST_ERR, DONE and PASS; set k=0; go to DRIVE.
  - DRIVE (1 cycle): registered operands update to the current k; BUSY=1. Go to SETTLE, or to CHECK if SETTLE_CYCLES=0.
  - SETTLE: down-counter runs SETTLE_CYCLES cycles, then go to CHECK.
  - CHECK (1 cycle): sample the flags.
    - Expected flags are exactly one-hot: GT=(A>B), EQ=(A==B), LT=(A<B), unsigned compare.
    - Any flag mismatch, including multiple flags or no flags asserted, is an error.
    - On error: increment ERR_COUNT, saturating at all-ones.
    - On the first error of the sweep: latch FIRST_ERR_A/B.
    - If k is all-ones: go to DONE; otherwise increment k and go to DRIVE.
  - DONE: BUSY=0, DONE=1, PASS=(ERR_COUNT==0). Operands hold the last pair; results hold. i_START restarts exactly as from IDLE.
- Operands are stable from the DRIVE edge through the end of CHECK; the comparator sees each pair for SETTLE_CYCLES+1 full cycles before sampling.
- Sweep latency: 2^(2W)*(2+SETTLE_CYCLES) cycles from the START edge to DONE rising. Defaults give 256*3 = 768 cycles.
- i_START is ignored while BUSY.
- i_START and i_RST_N low in the same cycle: reset wins.
- Reset mid-sweep: immediate return to IDLE with all outputs 0. No partial results are retained.
- Flags are sampled only in CHECK; flag values in other states are don't-care.
- k wrap-around never occurs; CHECK at k all-ones always exits to DONE.

Test Plan:
- Ideal comparator model, pulse i_START: BUSY=1 the next cycle, DONE rises 768 cycles after the START edge, ERR_COUNT=0, PASS=1, FIRST_ERR=(0,0).
- Model with EQ stuck at 0: ERR_COUNT=16, PASS=0, FIRST_ERR_A=0, FIRST_ERR_B=0.
- Model with GT and LT swapped: ERR_COUNT=240, FIRST_ERR_A=0, FIRST_ERR_B=1.
- Model asserting all three flags: ERR_COUNT=256, no saturation (limit 511); with SETTLE_CYCLES=0, DONE rises after 512 cycles.
- Drop i_RST_N at cycle 100 of a sweep: all outputs read 0 in the same cycle. Re-pulse i_START and the sweep restarts at (0,0). A START pulse issued while BUSY leaves the sweep timing unchanged.
- Model with SETTLE-dependent delay (flags valid 1 cycle after operand change) at SETTLE_CYCLES=0: errors are reported. At SETTLE_CYCLES=1: ERR_COUNT=0, PASS=1.
